// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Purpose:
//   Shares one late-control data-select mux between NREQ requesters. Each
//   cycle the round-robin scheduler picks one requester, evaluates the select
//   function on that requester's operand vector, select code and late flag,
//   and registers the resulting bit on a valid/ready output tagged with the
//   requester id. A new result can be loaded in the same cycle the previous
//   one is accepted, so throughput is one result per cycle.
//
//   Select function (A = 8-bit operand, C = 5-bit code):
//     p  = ~C[0] & C[1] & ~C[2]
//     z1 = C[0] ? A[0] : (C[2] ? A[2] : A[1])
//     Z  = (C[3] & ~late & p) ? A[3] : z1
//   A[7:4] and C[4] never influence Z.
//
// Optional feature (macro MUX_ARB_LOCK_EN):
//   Adds input req_lock and a two-state IDLE/LOCKED FSM. A transfer with its
//   lock bit set makes that requester the exclusive owner of the mux until it
//   issues an unlocked transfer or drops req_valid. While locked, the
//   round-robin pointer does not move.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   width of out_id, 2**IDW >= NREQ
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]    per-requester request valid
//   req_ready  [NREQ]    per-requester accept, one-hot or zero (combinational)
//   req_a      [8*NREQ]  operand vectors, requester i at [8i+7:8i]
//   req_c      [5*NREQ]  select codes, requester i at [5i+4:5i]
//   req_late   [NREQ]    late-control flag per requester
//   req_lock   [NREQ]    lock request per requester (MUX_ARB_LOCK_EN only)
//   out_valid            result valid
//   out_ready            downstream accept
//   out_z                selected bit
//   out_id     [IDW]     index of the requester that produced out_z
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [5*NREQ-1:0] req_c,
  input  logic [NREQ-1:0]   req_late,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_z,
  output logic [IDW-1:0]    out_id
);

  // Requester vectors are widened to the full id space so that any IDW-bit
  // index selects a defined entry even when NREQ is not a power of two.
  localparam int EXT = 1 << IDW;

  generate
    if (EXT < NREQ) begin : g_bad_idw
      $error("mux_sel_arbiter: IDW too small for NREQ");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic sel_f(input logic [3:0] a,
                                 input logic [3:0] c,
                                 input logic       late);
    logic p;
    logic z1;
    p  = ~c[0] & c[1] & ~c[2];
    z1 = c[0] ? a[0] : (c[2] ? a[2] : a[1]);
    return (c[3] & ~late & p) ? a[3] : z1;
  endfunction

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
    return (x == IDW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Input unpacking
  // ---------------------------------------------------------------------------
  logic [3:0]     a_lo [EXT];
  logic [3:0]     c_lo [EXT];
  logic [EXT-1:0] valid_ext;
  logic [EXT-1:0] late_ext;
  logic           unused_hi;

  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < EXT; i++) begin
      a_lo[i] = '0;
      c_lo[i] = '0;
    end
    unused_hi = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_lo[i]   = req_a[8*i +: 4];
      c_lo[i]   = req_c[5*i +: 4];
      // A[7:4] and C[4] are don't-care operand bits; folding them here keeps
      // them visibly consumed without reaching any logic.
      unused_hi = unused_hi ^ (^{req_a[8*i+4 +: 4], req_c[5*i+4]});
    end
  end

  assign valid_ext = EXT'(req_valid);
  assign late_ext  = EXT'(req_late);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [EXT-1:0] eligible;

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t    state_q;
  lock_state_t    state_d;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] owner_d;
  logic [EXT-1:0] lock_ext;

  assign lock_ext = EXT'(req_lock);

  // While locked, only the owner may win the mux.
  assign eligible = (state_q == LOCKED) ? (valid_ext & (EXT'(1) << owner_q))
                                        : valid_ext;
`else
  assign eligible = valid_ext;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin grant search: first eligible requester at or above the
  // pointer, wrapping from NREQ-1 back to 0.
  // ---------------------------------------------------------------------------
  logic           grant_hit;
  logic [IDW-1:0] grant_idx;

  always_comb begin : grant_search
    int idx;
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_hit && eligible[IDW'(idx)]) begin
        grant_hit = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  // The output slot can take a new result when it is empty or being drained
  // this cycle; that is what makes back-to-back transfers bubble-free.
  logic free;
  logic transfer;
  logic win_z;

  assign free      = ~out_valid | out_ready;
  assign transfer  = rst_n & free & grant_hit;
  assign req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;
  assign win_z     = sel_f(a_lo[grant_idx], c_lo[grant_idx], late_ext[grant_idx]);

  // ---------------------------------------------------------------------------
  // Next pointer / lock FSM
  // ---------------------------------------------------------------------------
`ifdef MUX_ARB_LOCK_EN
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (transfer) begin
      if (lock_ext[grant_idx]) begin
        // Locked transfers keep the pointer where it is.
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = IDLE;
        ptr_d   = inc_mod(grant_idx);
      end
    end else if (state_q == LOCKED && !valid_ext[owner_q]) begin
      // Owner walked away: release the lock and resume after the owner.
      state_d = IDLE;
      ptr_d   = inc_mod(owner_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) ptr_d = inc_mod(grant_idx);
  end
`endif

  // ---------------------------------------------------------------------------
  // Pointer and output registers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      out_valid <= 1'b0;
      out_z     <= 1'b0;
      out_id    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (transfer) begin
        out_valid <= 1'b1;
        out_z     <= win_z;
        out_id    <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
